// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the RV32M execute unit: opcode/func fields, func3 map, FSM states.
package ex_muldiv_pkg;

  localparam logic [6:0] OP_REG       = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] x);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Unsigned 32-step shift-add multiplier / restoring divider sharing one 64-bit accumulator.
module ex_muldiv_core
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_is_div,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic [63:0] o_acc,
  output logic        o_last
);

  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic [4:0]  r_cnt;
  logic        r_is_div;

  logic [32:0] w_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_part;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [63:0] w_div_next;

  // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
  assign w_sum      = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

  // Divide: partial remainder is below 2*divisor, so the borrow bit alone decides the subtract.
  assign w_part     = {r_acc[63:32], r_acc[31]};
  assign w_diff     = w_part - {1'b0, r_opb};
  assign w_ge       = ~w_diff[32];
  assign w_div_next = {(w_ge ? w_diff[31:0] : w_part[31:0]), r_acc[30:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_acc    <= {32'b0, i_op_a};
      r_opb    <= i_op_b;
      r_cnt    <= '0;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == 5'd31);

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute unit: decode, sign handling, divide special cases and the IDLE/BUSY/DONE FSM.
// Define MUL_FAST_EN to compute MUL* combinationally in the issue cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        hold_i,
  output logic        stallreq_o,
  output logic        valid_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o
);

  md_state_e   r_state;
  md_state_e   w_state_next;
  logic [2:0]  r_func3;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_special;
  logic [31:0] r_spec_res;

  logic        w_start, w_is_div, w_a_signed, w_b_signed, w_neg_a, w_neg_b;
  logic        w_div_zero, w_div_ovf, w_cap, w_step, w_core_last;
  logic [31:0] w_spec_res, w_result, w_quot, w_rem;
  logic [63:0] w_acc, w_prod;
  logic        w_fast_hit;
  logic [31:0] w_fast_data;

  assign w_start    = (opcode_i == OP_REG) && (func7_i == FUNC7_MULDIV);
  assign w_is_div   = func3_i[2];
  assign w_a_signed = (func3_i == F3_MULH) || (func3_i == F3_MULHSU) ||
                      (func3_i == F3_DIV)  || (func3_i == F3_REM);
  assign w_b_signed = (func3_i == F3_MULH) || (func3_i == F3_DIV) || (func3_i == F3_REM);
  assign w_neg_a    = w_a_signed & data1_i[31];
  assign w_neg_b    = w_b_signed & data2_i[31];

  assign w_div_zero = w_is_div && (data2_i == 32'h0);
  assign w_div_ovf  = w_is_div && w_a_signed && (data1_i == 32'h8000_0000) &&
                      (data2_i == 32'hFFFF_FFFF);
  // func3[1] distinguishes REM/REMU from DIV/DIVU.
  assign w_spec_res = w_div_zero ? (func3_i[1] ? data1_i : 32'hFFFF_FFFF)
                                 : (func3_i[1] ? 32'h0 : 32'h8000_0000);

`ifdef MUL_FAST_EN
  logic [63:0] w_fast_a, w_fast_b, w_fast_prod;
  assign w_fast_a    = {{32{w_neg_a}}, data1_i};
  assign w_fast_b    = {{32{w_neg_b}}, data2_i};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_hit  = w_start & ~w_is_div;
  assign w_fast_data = (func3_i == F3_MUL) ? w_fast_prod[31:0] : w_fast_prod[63:32];
`else
  assign w_fast_hit  = 1'b0;
  assign w_fast_data = 32'h0;
`endif

  ex_muldiv_core u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_cap),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_op_a   (cond_neg(w_neg_a, data1_i)),
    .i_op_b   (cond_neg(w_neg_b, data2_i)),
    .o_acc    (w_acc),
    .o_last   (w_core_last)
  );

  assign w_prod = (r_neg_a ^ r_neg_b) ? -w_acc : w_acc;
  assign w_quot = cond_neg(r_neg_a ^ r_neg_b, w_acc[31:0]);
  assign w_rem  = cond_neg(r_neg_a, w_acc[63:32]);

  always_comb begin
    w_result = w_prod[63:32];
    if (r_special) begin
      w_result = r_spec_res;
    end else begin
      unique case (r_func3)
        F3_MUL:           w_result = w_prod[31:0];
        F3_DIV, F3_DIVU:  w_result = w_quot;
        F3_REM, F3_REMU:  w_result = w_rem;
        default:          w_result = w_prod[63:32];
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cap        = 1'b0;
    w_step       = 1'b0;
    stallreq_o   = 1'b0;
    valid_o      = 1'b0;
    wdata_o      = 32'h0;
    wd_o         = 5'h0;
    wreg_o       = 1'b0;
    unique case (r_state)
      MD_IDLE: begin
        if (w_start && w_fast_hit) begin
          valid_o = 1'b1;
          wdata_o = w_fast_data;
          wd_o    = wd_i;
          wreg_o  = wreg_i;
        end else if (w_start) begin
          stallreq_o   = 1'b1;
          w_cap        = 1'b1;
          w_state_next = (w_div_zero || w_div_ovf) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        stallreq_o = 1'b1;
        w_step     = 1'b1;
        if (w_core_last) w_state_next = MD_DONE;
      end
      MD_DONE: begin
        valid_o = 1'b1;
        wdata_o = w_result;
        wd_o    = r_wd;
        wreg_o  = r_wreg;
        if (!hold_i) w_state_next = MD_IDLE;
      end
      default: w_state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= MD_IDLE;
      r_func3    <= '0;
      r_wd       <= '0;
      r_wreg     <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cap) begin
        r_func3    <= func3_i;
        r_wd       <= wd_i;
        r_wreg     <= wreg_i;
        r_neg_a    <= w_neg_a;
        r_neg_b    <= w_neg_b;
        r_special  <= w_div_zero | w_div_ovf;
        r_spec_res <= w_spec_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (honours MUL_FAST_EN for multiply latency).
module tb_ex_muldiv;

  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] F7M   = 7'b0000001;
`ifdef MUL_FAST_EN
  localparam int MulLat = 0;
`else
  localparam int MulLat = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [6:0]  func7_i;
  logic [31:0] data1_i, data2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, hold_i;
  logic        stallreq_o, valid_o, wreg_o;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;

  int errors = 0;
  int checks = 0;
  int tag = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .opcode_i   (opcode_i),
    .func3_i    (func3_i),
    .func7_i    (func7_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .hold_i     (hold_i),
    .stallreq_o (stallreq_o),
    .valid_o    (valid_o),
    .wdata_o    (wdata_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o)
  );

  task automatic bubble();
    opcode_i = OpImm;
    func7_i  = 7'h0;
    func3_i  = 3'h0;
    data1_i  = 32'h0;
    data2_i  = 32'h0;
    wd_i     = 5'h0;
    wreg_i   = 1'b0;
  endtask

  // Issues one M instruction at a negedge and follows it to its valid cycle.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    int stalls;
    logic [4:0] exp_wd;
    @(negedge clk);
    tag++;
    exp_wd   = 5'(tag);
    opcode_i = OpReg;
    func7_i  = F7M;
    func3_i  = f3;
    data1_i  = a;
    data2_i  = b;
    wd_i     = exp_wd;
    wreg_i   = 1'b1;
    #1;
    cyc    = 0;
    stalls = 0;
    while (!valid_o && cyc < 40) begin
      if (stallreq_o) stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat)
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
    if (cyc !== exp_lat) errors++;
    checks++;
    if (stalls !== exp_lat) begin
      $display("FAIL %s stall count: got %0d, expected %0d", name, stalls, exp_lat);
      errors++;
    end
    checks++;
    if (wdata_o !== exp) begin
      $display("FAIL %s wdata: got %h, expected %h", name, wdata_o, exp);
      errors++;
    end
    checks++;
    if (wd_o !== exp_wd || wreg_o !== 1'b1 || stallreq_o !== 1'b0) begin
      $display("FAIL %s wd/wreg/stall: got %0d/%b/%b, expected %0d/1/0", name, wd_o, wreg_o,
               stallreq_o, exp_wd);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    hold_i = 1'b0;
    bubble();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stallreq_o, valid_o, wdata_o, wd_o, wreg_o} !== 40'h0) begin
      $display("FAIL reset outputs: got stall=%b valid=%b wdata=%h wd=%0d wreg=%b, expected all 0",
               stallreq_o, valid_o, wdata_o, wd_o, wreg_o);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_non_m();
    @(negedge clk);
    opcode_i = OpReg;
    func7_i  = 7'h0;
    func3_i  = 3'h0;
    data1_i  = 32'd5;
    data2_i  = 32'd6;
    wreg_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        opcode_i = OpImm;
        func7_i  = F7M;
      end
      #1;
      checks++;
      if (stallreq_o !== 1'b0 || valid_o !== 1'b0) begin
        $display("FAIL non_m cycle %0d: got stall=%b valid=%b, expected 0/0", i, stallreq_o,
                 valid_o);
        errors++;
      end
      @(negedge clk);
    end
    bubble();
  endtask

  task automatic test_mul();
    run_op("mul_7_x_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
    run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
    run_op("mulh_m2_x_3", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MulLat);
    run_op("mulh_min_sq", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat);
    run_op("mul_6_x_7", 3'b000, 32'd6, 32'd7, 32'd42, MulLat);
  endtask

  task automatic test_div();
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_div_special();
    run_op("div_by_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by_zero", 3'b111, 32'd9, 32'd0, 32'd9, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul", 3'b000, 32'd1000, 32'd1000, 32'd1000000, MulLat);
    run_op("b2b_divu", 3'b101, 32'd1000000, 32'd1000, 32'd1000, 33);
  endtask

  task automatic test_hold();
    run_op("hold_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (valid_o !== 1'b1 || wdata_o !== 32'd14 || stallreq_o !== 1'b0) begin
        $display("FAIL hold cycle %0d: got valid=%b wdata=%h stall=%b, expected 1/0000000e/0",
                 i, valid_o, wdata_o, stallreq_o);
        errors++;
      end
    end
    hold_i = 1'b0;
    bubble();
    @(negedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
      $display("FAIL hold release: got valid=%b stall=%b, expected 0/0", valid_o, stallreq_o);
      errors++;
    end
  endtask

  task automatic test_reset_mid_busy();
    int pulses;
    @(negedge clk);
    opcode_i = OpReg;
    func7_i  = F7M;
    func3_i  = 3'b100;
    data1_i  = 32'hFFFF_FFF9;
    data2_i  = 32'd2;
    wd_i     = 5'd3;
    wreg_i   = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bubble();
    #1;
    checks++;
    if ({stallreq_o, valid_o, wdata_o, wd_o, wreg_o} !== 40'h0) begin
      $display("FAIL reset_mid_busy outputs: got stall=%b valid=%b wdata=%h, expected all 0",
               stallreq_o, valid_o, wdata_o);
      errors++;
    end
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid_o || stallreq_o) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      $display("FAIL reset_mid_busy aftermath: got %0d active cycles, expected 0", pulses);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_non_m();
    test_mul();
    test_div();
    test_div_special();
    test_back_to_back();
    test_hold();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
